// File: rtl/pwm32_pkg.sv
// Shared types and defaults for the PWM32 counting engine.
package pwm32_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/pwm32_prescaler.sv
// Prescaler: produces one tick every pre_s+1 enabled cycles.
module pwm32_prescaler
    import pwm32_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] pre_s,
    output logic         tick
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] pre_cnt_r;

    // Wrap is by equality so pre_s = all-ones still counts the full range.
    assign tick = enable && (pre_cnt_r == pre_s);

    // Prescaler counter: clear dominates, otherwise count or wrap on tick.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pre_cnt_r <= {W{1'b0}};
        end else if (clear) begin
            pre_cnt_r <= {W{1'b0}};
        end else if (enable) begin
            if (tick) begin
                pre_cnt_r <= {W{1'b0}};
            end else begin
                pre_cnt_r <= pre_cnt_r + ONE;
            end
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

endmodule

// File: rtl/pwm32_ctrl.sv
// PWM32 sequencing engine: FSM, period-boundary shadows, timer and PWM register.
module pwm32_ctrl
    import pwm32_pkg::*;
#(
    parameter int   W        = W_DEFAULT,
    parameter logic PWM_IDLE = 1'b0
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic [W-1:0] pre,
    input  logic [W-1:0] tmrcmp1,
    input  logic [W-1:0] tmrcmp2,
    input  logic         tmren,
    output logic         pwm,
    output logic         period_end,
    output logic         running,
    output logic [W-1:0] tmr_cnt
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_e       state_r;
    logic [W-1:0] pre_shd_r;
    logic [W-1:0] per_shd_r;
    logic [W-1:0] cmp_shd_r;
    logic [W-1:0] tmr_cnt_r;
    logic         pwm_r;
    logic         period_end_r;
    logic         tick_s;
    logic         in_run_s;
    logic         pre_clear_s;

    assign in_run_s    = (state_r == ST_RUN);
    assign pre_clear_s = !in_run_s || !tmren;

    pwm32_prescaler #(.W(W)) u_prescaler (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clear  (pre_clear_s),
        .enable (in_run_s),
        .pre_s  (pre_shd_r),
        .tick   (tick_s)
    );

    // Sequencer: state, shadows, timer and period-end strobe.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r      <= ST_IDLE;
            pre_shd_r    <= {W{1'b0}};
            per_shd_r    <= {W{1'b0}};
            cmp_shd_r    <= {W{1'b0}};
            tmr_cnt_r    <= {W{1'b0}};
            period_end_r <= 1'b0;
        end else begin
            period_end_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tmr_cnt_r <= {W{1'b0}};
                    if (tmren) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    pre_shd_r <= pre;
                    per_shd_r <= tmrcmp1;
                    cmp_shd_r <= tmrcmp2;
                    tmr_cnt_r <= {W{1'b0}};
                    if (tmren) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!tmren) begin
                        state_r   <= ST_IDLE;
                        tmr_cnt_r <= {W{1'b0}};
                    end else if (tick_s) begin
                        // Shadows only move at the wrap so live writes never glitch a period.
                        if (tmr_cnt_r == per_shd_r) begin
                            tmr_cnt_r    <= {W{1'b0}};
                            period_end_r <= 1'b1;
                            pre_shd_r    <= pre;
                            per_shd_r    <= tmrcmp1;
                            cmp_shd_r    <= tmrcmp2;
                        end else begin
                            tmr_cnt_r <= tmr_cnt_r + ONE;
                        end
                    end else begin
                        tmr_cnt_r <= tmr_cnt_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tmr_cnt_r <= {W{1'b0}};
                end
            endcase
        end
    end

    // PWM output register, one cycle behind the timer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pwm_r <= PWM_IDLE;
        end else if (in_run_s) begin
            pwm_r <= (tmr_cnt_r < cmp_shd_r);
        end else begin
            pwm_r <= PWM_IDLE;
        end
    end

    assign pwm        = pwm_r;
    assign period_end = period_end_r;
    assign running    = in_run_s;
    assign tmr_cnt    = tmr_cnt_r;

endmodule

// File: tb/tb_pwm32_ctrl.sv
// Directed scoreboard bench for pwm32_ctrl.
module tb_pwm32_ctrl;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] pre;
    logic [31:0] tmrcmp1;
    logic [31:0] tmrcmp2;
    logic        tmren;
    logic        pwm;
    logic        period_end;
    logic        running;
    logic [31:0] tmr_cnt;

    pwm32_ctrl #(.W(32), .PWM_IDLE(1'b0)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .pre        (pre),
        .tmrcmp1    (tmrcmp1),
        .tmrcmp2    (tmrcmp2),
        .tmren      (tmren),
        .pwm        (pwm),
        .period_end (period_end),
        .running    (running),
        .tmr_cnt    (tmr_cnt)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    function automatic int period_len(input int p, input int per);
        return (p + 1) * (per + 1);
    endfunction

    function automatic int active_len(input int p, input int per, input int cmp);
        return (p + 1) * ((cmp < per + 1) ? cmp : per + 1);
    endfunction

    // Steps until the next period_end sample, counting samples and pwm-high samples.
    task automatic measure(output int len, output int high, output bit ok);
        len  = 0;
        high = 0;
        ok   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            len++;
            if (pwm) high++;
            if (period_end) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic meas_check(input string name, input int exp_len, input int exp_high);
        int len, high;
        bit ok;
        push_exp({name, "_found"}, 32'd1);
        push_exp({name, "_len"}, exp_len);
        push_exp({name, "_high"}, exp_high);
        measure(len, high, ok);
        check_out({31'd0, ok});
        check_out(len);
        check_out(high);
    endtask

    task automatic meas_skip(input string name);
        int len, high;
        bit ok;
        push_exp({name, "_found"}, 32'd1);
        measure(len, high, ok);
        check_out({31'd0, ok});
    endtask

    task automatic wait_tmr(input string name, input logic [31:0] v);
        bit ok;
        ok = 1'b0;
        push_exp({name, "_found"}, 32'd1);
        for (int i = 0; i < 1000; i++) begin
            step();
            if (running && tmr_cnt == v) begin
                ok = 1'b1;
                break;
            end
        end
        check_out({31'd0, ok});
    endtask

    initial begin
        int pe_cnt, zero_cnt;

        // Reset with enable already high
        PRESET  = 1'b1;
        tmren   = 1'b1;
        pre     = 32'd0;
        tmrcmp1 = 32'd9;
        tmrcmp2 = 32'd3;
        step();
        step();
        push_exp("rst_pwm", 32'd0);
        push_exp("rst_running", 32'd0);
        push_exp("rst_tmr", 32'd0);
        push_exp("rst_pe", 32'd0);
        check_out({31'd0, pwm});
        check_out({31'd0, running});
        check_out(tmr_cnt);
        check_out({31'd0, period_end});

        PRESET = 1'b0;
        push_exp("load_running", 32'd0);
        step();
        check_out({31'd0, running});
        push_exp("run_running", 32'd1);
        push_exp("run_tmr", 32'd0);
        step();
        check_out({31'd0, running});
        check_out(tmr_cnt);

        // Basic waveform: from RUN entry to first wrap, then one full period
        meas_check("basic_first", period_len(0, 9), active_len(0, 9, 3));
        meas_check("basic", period_len(0, 9), active_len(0, 9, 3));

        // Shadowing: compare change mid-period waits for the wrap
        wait_tmr("shadow_t5", 32'd5);
        tmrcmp2 = 32'd7;
        meas_check("shadow_rest", 5, 0);
        meas_check("shadow_next", period_len(0, 9), active_len(0, 9, 7));

        // Prescaled
        pre     = 32'd1;
        tmrcmp1 = 32'd3;
        tmrcmp2 = 32'd2;
        meas_skip("presc_transition");
        meas_check("prescaled", period_len(1, 3), active_len(1, 3, 2));
        push_exp("presc_tmr_hold", 32'd0);
        step();
        check_out(tmr_cnt);
        push_exp("presc_tmr_step", 32'd1);
        step();
        check_out(tmr_cnt);

        // Extremes: 0% and 100% duty
        pre     = 32'd0;
        tmrcmp1 = 32'd9;
        tmrcmp2 = 32'd0;
        meas_skip("duty0_transition");
        meas_check("duty0", period_len(0, 9), active_len(0, 9, 0));
        tmrcmp2 = 32'd20;
        meas_skip("duty100_transition");
        meas_check("duty100", period_len(0, 9), active_len(0, 9, 20));

        // Period of one timer value: period_end every cycle
        tmrcmp1 = 32'd0;
        tmrcmp2 = 32'd1;
        meas_skip("per0_transition");
        pe_cnt   = 0;
        zero_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (period_end) pe_cnt++;
            if (tmr_cnt == 32'd0) zero_cnt++;
        end
        push_exp("per0_pe_count", 32'd5);
        push_exp("per0_tmr_zero", 32'd5);
        check_out(pe_cnt);
        check_out(zero_cnt);

        // Disable mid-run at tmr_cnt=4 with pwm high
        tmrcmp1 = 32'd9;
        tmrcmp2 = 32'd9;
        meas_skip("dis_transition");
        wait_tmr("dis_t4", 32'd4);
        tmren = 1'b0;
        push_exp("dis1_running", 32'd0);
        push_exp("dis1_tmr", 32'd0);
        push_exp("dis1_pwm", 32'd1);
        push_exp("dis1_pe", 32'd0);
        step();
        check_out({31'd0, running});
        check_out(tmr_cnt);
        check_out({31'd0, pwm});
        check_out({31'd0, period_end});
        push_exp("dis2_pwm", 32'd0);
        push_exp("dis2_running", 32'd0);
        step();
        check_out({31'd0, pwm});
        check_out({31'd0, running});

        // Restart through LOAD with fresh shadows
        pre     = 32'd0;
        tmrcmp1 = 32'd5;
        tmrcmp2 = 32'd6;
        tmren   = 1'b1;
        push_exp("restart_load_running", 32'd0);
        step();
        check_out({31'd0, running});
        push_exp("restart_running", 32'd1);
        push_exp("restart_tmr", 32'd0);
        step();
        check_out({31'd0, running});
        check_out(tmr_cnt);
        meas_check("restart", period_len(0, 5), active_len(0, 5, 6));

        // Reset on the wrap edge: no period_end, everything back to reset values
        wait_tmr("rst_t5", 32'd5);
        PRESET = 1'b1;
        push_exp("midrst_pe", 32'd0);
        push_exp("midrst_pwm", 32'd0);
        push_exp("midrst_running", 32'd0);
        push_exp("midrst_tmr", 32'd0);
        step();
        check_out({31'd0, period_end});
        check_out({31'd0, pwm});
        check_out({31'd0, running});
        check_out(tmr_cnt);
        PRESET = 1'b0;
        step();

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
